// File: rtl/ipdc_host.sv
// ipdc_host: drives an image-processing core (ipdc) from op and pixel
// memories and checks its result stream against a golden memory.
// An op of 4'b0000 is a "load" op: it streams the full 256-entry pixel
// memory to the core before the next op is issued.
module ipdc_host (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [6:0]  i_op_cnt,
  input  logic [10:0] i_gold_cnt,
  output logic [5:0]  o_op_addr,
  input  logic [3:0]  i_op_data,
  output logic [7:0]  o_pix_addr,
  input  logic [23:0] i_pix_data,
  output logic [9:0]  o_gold_addr,
  input  logic [23:0] i_gold_data,
  output logic        o_op_valid,
  output logic [3:0]  o_op_mode,
  input  logic        i_op_ready,
  output logic        o_in_valid,
  output logic [23:0] o_in_data,
  input  logic        i_in_ready,
  input  logic        i_out_valid,
  input  logic [23:0] i_out_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [10:0] o_err_cnt,
  output logic        o_pass,
  output logic [2:0]  dbg_state
);

  // Handshakes: o_op_valid is a one-cycle strobe (the core's readiness is
  // sampled via i_op_ready only while waiting to issue). A pixel transfers
  // on every rising edge where o_in_valid & i_in_ready; while i_in_ready is
  // low, o_in_valid and o_in_data hold. i_out_valid is a one-cycle result
  // strobe with no back-pressure.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ISSUE    = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [6:0]  op_ptr;
  logic [7:0]  pix_ptr;
  logic [10:0] gold_ptr;

  logic        clear;
  logic        hs;
  logic        last_pix;
  logic        chk;
  logic        miss;
  logic [10:0] gold_ptr_n;
  logic [10:0] err_n;

  // Memory addresses come straight from the pointer registers. The pixel
  // address is its own register because it runs one entry ahead of the
  // pixel being presented, so the next word is ready on each handshake.
  assign o_op_addr   = op_ptr[5:0];
  assign o_gold_addr = gold_ptr[9:0];
  assign dbg_state   = state;

  assign hs       = (state == LOAD) && o_in_valid && i_in_ready;
  assign last_pix = (pix_ptr == 8'hFF);

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_n = state;
    clear   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          clear   = 1'b1;
          state_n = (i_op_cnt == 7'd0) ? DONE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_op_ready) begin
          state_n = (op_ptr < i_op_cnt) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        state_n = (o_op_mode == 4'b0000) ? LOAD : WAIT_RDY;
      end
      LOAD: begin
        if (hs && last_pix) begin
          state_n = WAIT_RDY;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Result checking: every result outside IDLE consumes one golden entry;
  // results beyond the expected count are errors regardless of value.
  always_comb begin
    chk        = i_out_valid && (state != IDLE) && !clear;
    miss       = chk && ((gold_ptr >= i_gold_cnt) || (i_out_data != i_gold_data));
    gold_ptr_n = gold_ptr;
    err_n      = o_err_cnt;
    if (clear) begin
      gold_ptr_n = 11'd0;
      err_n      = 11'd0;
    end else begin
      if (chk) begin
        gold_ptr_n = gold_ptr + 11'd1;
      end
      if (miss && (o_err_cnt != 11'h7FF)) begin
        err_n = o_err_cnt + 11'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Op pointer and op strobe; the mode is captured in the cycle before
  // ISSUE, when the op memory is already addressed by op_ptr.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_ptr     <= 7'd0;
      o_op_valid <= 1'b0;
      o_op_mode  <= 4'd0;
    end else begin
      o_op_valid <= (state_n == ISSUE);
      if (clear) begin
        op_ptr <= 7'd0;
      end else if (state == ISSUE) begin
        op_ptr <= op_ptr + 7'd1;
      end
      if ((state == WAIT_RDY) && (state_n == ISSUE)) begin
        o_op_mode <= i_op_data;
      end
    end
  end

  // Pixel streaming with one-ahead prefetch of the pixel memory.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix_ptr    <= 8'd0;
      o_pix_addr <= 8'd0;
      o_in_valid <= 1'b0;
      o_in_data  <= 24'd0;
    end else if (clear) begin
      pix_ptr    <= 8'd0;
      o_pix_addr <= 8'd0;
      o_in_valid <= 1'b0;
    end else if ((state == ISSUE) && (state_n == LOAD)) begin
      o_in_valid <= 1'b1;
      o_in_data  <= i_pix_data;
      o_pix_addr <= pix_ptr + 8'd1;
    end else if (hs) begin
      pix_ptr <= pix_ptr + 8'd1;
      if (last_pix) begin
        o_in_valid <= 1'b0;
        o_pix_addr <= 8'd0;
      end else begin
        o_in_data  <= i_pix_data;
        o_pix_addr <= pix_ptr + 8'd2;
      end
    end
  end

  // Golden pointer, error counter and run status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gold_ptr  <= 11'd0;
      o_err_cnt <= 11'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
    end else begin
      gold_ptr  <= gold_ptr_n;
      o_err_cnt <= err_n;
      o_busy    <= (state_n == WAIT_RDY) || (state_n == ISSUE) || (state_n == LOAD);
      o_done    <= (state_n == DONE);
      o_pass    <= (state_n == DONE) && (err_n == 11'd0) && (gold_ptr_n == i_gold_cnt);
    end
  end

endmodule
